bomb_controller: RTL
====================

Name: bomb_controller

Overview:
- Upstream of the enemy and bomberman hazard logic. Owns the single on-screen bomb.
- Latches the player's tile-snapped drop position, then runs a fuse countdown.
- Runs the explosion phase, during which it drives the explosion centre (e_x/e_y) and a periodic explosion_SCEN strobe; enemies and bomberman use that strobe to evaluate kills.
- Also provides the bomb_on/explosion_on pixel flags that the top-level display mux consumes.

Parameters:
- FUSE_CYCLES, 150000000, cycles spent in ARMED (1.5 s at 100 MHz).
- EXPLODE_CYCLES, 50000000, cycles spent in EXPLODING.
- SCAN_PERIOD, 1000000, spacing of explosion_SCEN pulses within EXPLODING; must be ≥1.
- CNT_W, 28, width of the shared phase counter; must hold max(FUSE_CYCLES, EXPLODE_CYCLES).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- place_btn  in  1  debounced drop-bomb button, level
- game_over  in  1  freezes and clears the bomb while high
- b_x  in  10  bomberman top-left x
- b_y  in  10  bomberman top-left y
- v_x  in  10  current VGA pixel x
- v_y  in  10  current VGA pixel y
- bomb_active  out  1  high in ARMED
- bomb_x  out  10  snapped bomb x
- bomb_y  out  10  snapped bomb y
- e_x  out  10  explosion centre x, equal to bomb_x
- e_y  out  10  explosion centre y, equal to bomb_y
- explosion_active  out  1  high in EXPLODING
- explosion_SCEN  out  1  one-cycle kill-scan strobe
- bomb_on  out  1  pixel inside bomb tile
- explosion_on  out  1  pixel inside explosion plus

Behaviour:

Reset:
- State IDLE.
- All outputs 0: bomb_x, bomb_y, e_x, e_y, bomb_active, explosion_active, explosion_SCEN.
- Phase counter 0, scan counter 0, place_prev 0.

Edge detect:
- place_prev is registered from place_btn.
- place_edge = place_btn & ~place_prev.
- A button held through reset release yields an edge on the first clock.

Snap (combinational, evaluated on b_x/b_y):
- Constants: MIN_X=143, MIN_Y=34, tile 16.
- kx = (b_x − MIN_X + 8) >> 4, clamped to 0..39. b_x < MIN_X gives kx = 0. Use 11-bit intermediates.
- ky = (b_y − MIN_Y + 8) >> 4, clamped to 0..29.
- snap_x = MIN_X + 16·kx (max 767).
- snap_y = MIN_Y + 16·ky (max 498).

FSM:
- IDLE:
  - On place_edge and !game_over: latch bomb_x/e_x ← snap_x and bomb_y/e_y ← snap_y, counter ← 0, go to ARMED.
- ARMED:
  - bomb_active = 1; counter increments each cycle.
  - When counter == FUSE_CYCLES−1: counter ← 0, scan counter ← 0, go to EXPLODING. ARMED therefore lasts exactly FUSE_CYCLES cycles.
  - place_edge is ignored.
- EXPLODING:
  - explosion_active = 1.
  - explosion_SCEN = 1 on EXPLODING cycle k (k = 0..EXPLODE_CYCLES−1) iff k mod SCAN_PERIOD == 0. The first cycle always strobes.
  - SCEN is registered and coincident with explosion_active.
  - When counter == EXPLODE_CYCLES−1: go to IDLE.
  - e_x/e_y hold stable for the whole phase; place_edge is ignored.
- Return to IDLE:
  - On the IDLE return cycle, bomb_x/y and e_x/e_y hold their last values; only the active flags drop.
  - A new drop needs a fresh place_edge, so a button held through the explosion does not re-arm.

game_over:
- When high in any state, next state is IDLE. bomb_active, explosion_active and explosion_SCEN go 0 on the next cycle; counters reset.
- game_over takes priority over a same-cycle fuse expiry, so no SCEN is issued, and over a same-cycle place_edge, so nothing is latched.

Pixel flags (combinational):
- bomb_on = bomb_active && bomb_x ≤ v_x ≤ bomb_x+15 && bomb_y ≤ v_y ≤ bomb_y+15.
- explosion_on = explosion_active && (H || V).
  - H: e_x−48 ≤ v_x ≤ e_x+63 && e_y ≤ v_y ≤ e_y+15.
  - V: e_y−48 ≤ v_y ≤ e_y+63 && e_x ≤ v_x ≤ e_x+15.
  - Compute in 11-bit signed so that lower bounds below 0 do not wrap.

Test Plan:
- Snap: b_x=200, b_y=100, place pulse → bomb_x=e_x=207, bomb_y=e_y=98, bomb_active=1 the next cycle. b_x=10, b_y=700 → 143 and 498.
- Timing with FUSE=10, EXPLODE=8, SCAN=3, edge on cycle 0 → bomb_active cycles 1–10; explosion_active cycles 11–18; SCEN exactly at 11, 14, 17; IDLE at 19.
- Held button: place_btn held high from cycle 0 through cycle 30 → exactly one bomb cycle. Release then re-press → second bomb latched at the new b_x/b_y.
- Re-press while ARMED with b_x moved to 300 → ignored; bomb_x unchanged at 207.
- game_over asserted on cycle 10 (the fuse-expiry cycle) → no SCEN; all flags 0 at cycle 11; IDLE.
- Pixel flags with e=(207,98) during EXPLODING: (159,100)→on; (270,113)→on; (271,100)→off; (210,50)→on; (223,50)→off; (210,161)→on. Mid-ARMED async reset → all outputs 0 immediately.

Source files
------------

// File: rtl/bomb_controller.sv
// Single-bomb controller: latches a tile-snapped drop position, runs the fuse
// and explosion phases, and drives kill-scan strobes plus pixel overlay flags.
module bomb_controller #(
  parameter int unsigned FUSE_CYCLES    = 150000000,
  parameter int unsigned EXPLODE_CYCLES = 50000000,
  parameter int unsigned SCAN_PERIOD    = 1000000,
  parameter int unsigned CNT_W          = 28
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       place_btn,
  input  logic       game_over,
  input  logic [9:0] b_x,
  input  logic [9:0] b_y,
  input  logic [9:0] v_x,
  input  logic [9:0] v_y,
  output logic       bomb_active,
  output logic [9:0] bomb_x,
  output logic [9:0] bomb_y,
  output logic [9:0] e_x,
  output logic [9:0] e_y,
  output logic       explosion_active,
  output logic       explosion_SCEN,
  output logic       bomb_on,
  output logic       explosion_on
);

  typedef enum logic [1:0] {IDLE, ARMED, EXPLODING} state_e;

  localparam logic [CNT_W-1:0] FUSE_LAST    = CNT_W'(FUSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] EXPLODE_LAST = CNT_W'(EXPLODE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SCAN_LAST    = CNT_W'(SCAN_PERIOD - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] scan_q, scan_d;
  logic             place_prev_q, place_prev_d;
  logic [9:0]       bomb_x_q, bomb_x_d;
  logic [9:0]       bomb_y_q, bomb_y_d;
  logic             scen_q, scen_d;
  logic             place_edge;

  logic [10:0] dx, dy;
  logic [6:0]  kx_raw, ky_raw;
  logic [5:0]  kx, ky;
  logic [9:0]  snap_x, snap_y;

  assign place_edge = place_btn & ~place_prev_q;

  // Snap to the nearest 16-pixel tile, clamped to the playfield grid.
  always_comb begin
    dx     = ({1'b0, b_x} < 11'd143) ? '0 : ({1'b0, b_x} - 11'd143 + 11'd8);
    dy     = ({1'b0, b_y} < 11'd34)  ? '0 : ({1'b0, b_y} - 11'd34  + 11'd8);
    kx_raw = dx[10:4];
    ky_raw = dy[10:4];
    kx     = (kx_raw > 7'd39) ? 6'd39 : kx_raw[5:0];
    ky     = (ky_raw > 7'd29) ? 6'd29 : ky_raw[5:0];
    snap_x = 10'd143 + {kx, 4'b0000};
    snap_y = 10'd34  + {ky, 4'b0000};
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    scan_d       = scan_q;
    place_prev_d = place_btn;
    bomb_x_d     = bomb_x_q;
    bomb_y_d     = bomb_y_q;
    scen_d       = 1'b0;
    if (game_over) begin
      state_d = IDLE;
      cnt_d   = '0;
      scan_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (place_edge) begin
            bomb_x_d = snap_x;
            bomb_y_d = snap_y;
            state_d  = ARMED;
          end
        end
        ARMED: begin
          if (cnt_q == FUSE_LAST) begin
            cnt_d   = '0;
            scan_d  = '0;
            scen_d  = 1'b1;
            state_d = EXPLODING;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        EXPLODING: begin
          if (cnt_q == EXPLODE_LAST) begin
            cnt_d   = '0;
            scan_d  = '0;
            state_d = IDLE;
          end else begin
            // scan_q tracks the current cycle's position; strobe the next one on wrap
            cnt_d  = cnt_q + 1'b1;
            scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + 1'b1;
            scen_d = (scan_q == SCAN_LAST);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      scan_q       <= '0;
      place_prev_q <= 1'b0;
      bomb_x_q     <= '0;
      bomb_y_q     <= '0;
      scen_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      scan_q       <= scan_d;
      place_prev_q <= place_prev_d;
      bomb_x_q     <= bomb_x_d;
      bomb_y_q     <= bomb_y_d;
      scen_q       <= scen_d;
    end
  end

  assign bomb_active      = (state_q == ARMED);
  assign explosion_active = (state_q == EXPLODING);
  assign explosion_SCEN   = scen_q;
  assign bomb_x           = bomb_x_q;
  assign bomb_y           = bomb_y_q;
  assign e_x              = bomb_x_q;
  assign e_y              = bomb_y_q;

  logic signed [10:0] vx, vy, ex, ey;
  logic               h_arm, v_arm;

  always_comb begin
    vx      = $signed({1'b0, v_x});
    vy      = $signed({1'b0, v_y});
    ex      = $signed({1'b0, bomb_x_q});
    ey      = $signed({1'b0, bomb_y_q});
    h_arm   = (vx >= ex - 11'sd48) && (vx <= ex + 11'sd63) &&
              (vy >= ey) && (vy <= ey + 11'sd15);
    v_arm   = (vy >= ey - 11'sd48) && (vy <= ey + 11'sd63) &&
              (vx >= ex) && (vx <= ex + 11'sd15);
    bomb_on = bomb_active && (vx >= ex) && (vx <= ex + 11'sd15) &&
              (vy >= ey) && (vy <= ey + 11'sd15);
    explosion_on = explosion_active && (h_arm || v_arm);
  end

endmodule
